// File: rtl/packet_mem_reader.sv
// Length-FIFO driven reader of the receive round buffer.
// Streams each packet as bytes with sop/eop over valid/ready.
module packet_mem_reader #(
  parameter int pRB_WIDHT  = 14,
  parameter int pFIFO_SIZE = 16,
  parameter int pMEM_WIDTH = 8
) (
  input  logic                  iclk,
  input  logic                  i_rst,
  input  logic                  iempty,
  input  logic [pFIFO_SIZE-1:0] ilen_pac,
  output logic                  ofifo_rd,
  output logic [pRB_WIDHT-1:0]  or_addr,
  input  logic [pMEM_WIDTH-1:0] ird_data,
  output logic                  ord_en,
  output logic [pMEM_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [pRB_WIDHT-1:0] PTR_ONE =
    {{(pRB_WIDHT-1){1'b0}}, 1'b1};
  localparam logic [pFIFO_SIZE-1:0] REM_ONE =
    {{(pFIFO_SIZE-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [pRB_WIDHT-1:0]    ptr_q, ptr_d;
  logic [pFIFO_SIZE-1:0]   rem_q, rem_d;
  logic                    first_q, first_d;

  logic                    pend_q, pend_d;
  logic                    pend_sop_q, pend_sop_d;
  logic                    pend_eop_q, pend_eop_d;

  logic                    hd_vld_q, hd_vld_d;
  logic [pMEM_WIDTH-1:0]   hd_data_q, hd_data_d;
  logic                    hd_sop_q, hd_sop_d;
  logic                    hd_eop_q, hd_eop_d;

  logic                    sk_vld_q, sk_vld_d;
  logic [pMEM_WIDTH-1:0]   sk_data_q, sk_data_d;
  logic                    sk_sop_q, sk_sop_d;
  logic                    sk_eop_q, sk_eop_d;

  logic       pop;
  logic       eop_done;
  logic [1:0] used;
  logic       space;
  logic       rd;
  logic       load;

  always_comb begin
    pop      = hd_vld_q & i_ready;
    eop_done = pop & hd_eop_q;
    // held bytes plus the read whose data lands next edge
    used     = {1'b0, hd_vld_q} + {1'b0, sk_vld_q}
             + {1'b0, pend_q};
    space    = (used < 2'd2) | (pop & (used == 2'd2));
    rd       = (state_q == STREAM) & (rem_q != '0) & space;
    load     = ~i_rst & ~iempty &
               ((state_q == IDLE) |
                ((state_q == DRAIN) & eop_done));

    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    first_d = first_q;
    case (state_q)
      STREAM: begin
        if (rd) begin
          ptr_d   = ptr_q + PTR_ONE;
          rem_d   = rem_q - REM_ONE;
          first_d = 1'b0;
          if (rem_q == REM_ONE) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (eop_done) state_d = IDLE;
      end
      default: ;
    endcase
    if (load) begin
      rem_d   = ilen_pac;
      first_d = 1'b1;
      state_d = (ilen_pac == '0) ? IDLE : STREAM;
    end

    pend_d     = rd;
    pend_sop_d = rd & first_q;
    pend_eop_d = rd & (rem_q == REM_ONE);
  end

  always_comb begin
    hd_vld_d  = hd_vld_q;
    hd_data_d = hd_data_q;
    hd_sop_d  = hd_sop_q;
    hd_eop_d  = hd_eop_q;
    sk_vld_d  = sk_vld_q;
    sk_data_d = sk_data_q;
    sk_sop_d  = sk_sop_q;
    sk_eop_d  = sk_eop_q;
    if (~hd_vld_q | pop) begin
      if (sk_vld_q) begin
        hd_vld_d  = 1'b1;
        hd_data_d = sk_data_q;
        hd_sop_d  = sk_sop_q;
        hd_eop_d  = sk_eop_q;
        sk_vld_d  = pend_q;
        if (pend_q) begin
          sk_data_d = ird_data;
          sk_sop_d  = pend_sop_q;
          sk_eop_d  = pend_eop_q;
        end
      end else begin
        hd_vld_d = pend_q;
        sk_vld_d = 1'b0;
        if (pend_q) begin
          hd_data_d = ird_data;
          hd_sop_d  = pend_sop_q;
          hd_eop_d  = pend_eop_q;
        end
      end
    end else if (pend_q) begin
      sk_vld_d  = 1'b1;
      sk_data_d = ird_data;
      sk_sop_d  = pend_sop_q;
      sk_eop_d  = pend_eop_q;
    end
  end

  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      first_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_sop_q <= 1'b0;
      pend_eop_q <= 1'b0;
      hd_vld_q   <= 1'b0;
      hd_data_q  <= '0;
      hd_sop_q   <= 1'b0;
      hd_eop_q   <= 1'b0;
      sk_vld_q   <= 1'b0;
      sk_data_q  <= '0;
      sk_sop_q   <= 1'b0;
      sk_eop_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      first_q    <= first_d;
      pend_q     <= pend_d;
      pend_sop_q <= pend_sop_d;
      pend_eop_q <= pend_eop_d;
      hd_vld_q   <= hd_vld_d;
      hd_data_q  <= hd_data_d;
      hd_sop_q   <= hd_sop_d;
      hd_eop_q   <= hd_eop_d;
      sk_vld_q   <= sk_vld_d;
      sk_data_q  <= sk_data_d;
      sk_sop_q   <= sk_sop_d;
      sk_eop_q   <= sk_eop_d;
    end
  end

  assign ofifo_rd = load;
  assign ord_en   = rd;
  assign or_addr  = ptr_q;
  assign o_data   = hd_data_q;
  assign o_valid  = hd_vld_q;
  assign o_sop    = hd_sop_q;
  assign o_eop    = hd_eop_q;
  assign o_busy   = (state_q != IDLE) | hd_vld_q | sk_vld_q;

endmodule

// File: tb/tb_packet_mem_reader.sv
// Scoreboard bench: length FIFO, sync-read memory and sink models
// around packet_mem_reader, with randomized lengths and backpressure.
module tb_packet_mem_reader;

  typedef struct packed {
    logic       s;
    logic       e;
    logic [7:0] d;
  } exp_t;

  logic        iclk = 1'b0;
  logic        i_rst;
  logic        iempty;
  logic [15:0] ilen_pac;
  logic        ofifo_rd;
  logic [13:0] or_addr;
  logic [7:0]  ird_data;
  logic        ord_en;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_sop;
  logic        o_eop;
  logic        o_busy;

  always #5 iclk = ~iclk;

  packet_mem_reader #(
    .pRB_WIDHT (14),
    .pFIFO_SIZE(16),
    .pMEM_WIDTH(8)
  ) dut (
    .iclk    (iclk),
    .i_rst   (i_rst),
    .iempty  (iempty),
    .ilen_pac(ilen_pac),
    .ofifo_rd(ofifo_rd),
    .or_addr (or_addr),
    .ird_data(ird_data),
    .ord_en  (ord_en),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_sop   (o_sop),
    .o_eop   (o_eop),
    .o_busy  (o_busy)
  );

  logic [7:0]  mem [16384];
  logic [15:0] lq [$];
  exp_t        eq [$];
  logic [13:0] aq [$];
  int          sop_cyc [$];
  int          eop_cyc [$];

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int npops = 0;
  int nacc = 0;
  int pop_cyc = 0;
  int first_rd = -1;
  int rmode = 0;
  int rk = 0;
  int mptr = 0;

  bit          pop_flag = 1'b0;
  bit          rd_flag = 1'b0;
  logic [13:0] rd_addr_s = '0;
  bit          prev_v = 1'b0;
  bit          prev_r = 1'b0;
  logic        prev_s = 1'b0;
  logic        prev_e = 1'b0;
  logic [7:0]  prev_d = '0;
  logic [5:0]  pat = 6'b101001;
  exp_t        mon_e;
  logic [13:0] mon_a;

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] outs();
    return {4'h0, o_busy, ord_en, ofifo_rd, o_valid,
            o_sop, o_eop, o_data, or_addr};
  endfunction

  // reference: packet i occupies the next len bytes after the previous one
  task automatic push_len(int len);
    exp_t e;
    lq.push_back(16'(len));
    for (int i = 0; i < len; i++) begin
      aq.push_back(14'(mptr));
      e.d = mem[mptr];
      e.s = (i == 0);
      e.e = (i == len - 1);
      eq.push_back(e);
      mptr = (mptr + 1) % 16384;
    end
  endtask

  always @(posedge iclk) cyc++;

  // input driver: FIFO head, memory data, sink ready
  always begin
    @(posedge iclk);
    #1;
    if (pop_flag) begin
      if (lq.size() > 0) lq.delete(0);
      pop_flag = 1'b0;
    end
    ird_data = rd_flag ? mem[rd_addr_s] : 8'($urandom);
    rd_flag = 1'b0;
    case (rmode)
      0: i_ready = 1'b1;
      1: begin
        i_ready = pat[rk % 6];
        rk++;
      end
      default: i_ready = ($urandom_range(0, 3) != 0);
    endcase
    iempty = (lq.size() == 0);
    ilen_pac = iempty ? 16'h0 : lq[0];
  end

  // monitor
  always @(negedge iclk) begin
    if (i_rst) begin
      prev_v = 1'b0;
      rd_flag = 1'b0;
    end else begin
      if (ofifo_rd) begin
        chk("pop_when_empty", {31'h0, iempty}, 0);
        pop_flag = 1'b1;
        npops++;
        pop_cyc = cyc;
      end
      rd_flag = ord_en;
      rd_addr_s = or_addr;
      if (ord_en) begin
        if (first_rd < 0) first_rd = cyc;
        if (aq.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL extra_read: got addr %0d want none",
                   or_addr);
        end else begin
          mon_a = aq.pop_front();
          chk("rd_addr", {18'h0, or_addr}, {18'h0, mon_a});
        end
      end
      if (prev_v && !prev_r)
        chk("hold_stable",
            {21'h0, o_valid, o_sop, o_eop, o_data},
            {21'h0, 1'b1, prev_s, prev_e, prev_d});
      if (o_valid && o_sop && !(prev_v && !prev_r))
        sop_cyc.push_back(cyc);
      if (o_valid && i_ready) begin
        nacc++;
        if (o_eop) eop_cyc.push_back(cyc);
        if (eq.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL extra_byte: got %0h want none", o_data);
        end else begin
          mon_e = eq.pop_front();
          chk("byte", {21'h0, o_sop, o_eop, o_data},
              {21'h0, mon_e});
        end
      end
      prev_v = o_valid;
      prev_r = i_ready;
      prev_s = o_sop;
      prev_e = o_eop;
      prev_d = o_data;
    end
  end

  task automatic wait_done(string name, int bound);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < bound) begin
      @(negedge iclk);
      n++;
      done = (lq.size() == 0) && (eq.size() == 0) &&
             (aq.size() == 0) && !o_busy && !ofifo_rd;
    end
    chk(name, {31'h0, done}, 1);
    repeat (4) @(negedge iclk);
  endtask

  task automatic do_reset();
    @(posedge iclk);
    #3;
    i_rst = 1'b1;
    #1;
    chk("rst_outputs", outs(), 0);
    lq.delete();
    eq.delete();
    aq.delete();
    pop_flag = 1'b0;
    mptr = 0;
    iempty = 1'b1;
    ilen_pac = 16'h0;
    repeat (2) @(negedge iclk);
    #2;
    i_rst = 1'b0;
  endtask

  task automatic clr_marks();
    first_rd = -1;
    sop_cyc.delete();
    eop_cyc.delete();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int np0;
    int na0;
    int gap;
    int n;
    i_rst = 1'b1;
    iempty = 1'b1;
    ilen_pac = 16'h0;
    i_ready = 1'b0;
    ird_data = 8'h0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) mem[i] = 8'hA0 + 8'(i);
    #12;
    chk("por_outputs", outs(), 0);
    @(negedge iclk);
    #2;
    i_rst = 1'b0;

    // single 5-byte packet, latency and pointer
    do_reset();
    rmode = 0;
    clr_marks();
    np0 = npops;
    @(negedge iclk);
    push_len(5);
    wait_done("t1_done", 100);
    chk("t1_pops", npops - np0, 1);
    chk("t1_rd_lat", first_rd - pop_cyc, 1);
    chk("t1_sop_lat",
        (sop_cyc.size() > 0) ? sop_cyc[0] - pop_cyc : -1, 3);
    chk("t1_eop_lat",
        (eop_cyc.size() > 0) ? eop_cyc[0] - pop_cyc : -1, 7);
    chk("t1_ptr", {18'h0, or_addr}, 5);

    // back-to-back 3 then 2
    do_reset();
    clr_marks();
    np0 = npops;
    @(negedge iclk);
    push_len(3);
    push_len(2);
    wait_done("t2_done", 100);
    chk("t2_pops", npops - np0, 2);
    gap = (sop_cyc.size() > 1 && eop_cyc.size() > 0) ?
          sop_cyc[1] - eop_cyc[0] : -1;
    chk("t2_b2b_gap", {31'h0, (gap >= 1 && gap <= 3)}, 1);
    chk("t2_ptr", {18'h0, or_addr}, 5);

    // length 6 under ready pattern 1,0,0,1,0,1
    do_reset();
    rmode = 1;
    rk = 0;
    @(negedge iclk);
    push_len(6);
    wait_done("t3_done", 200);
    chk("t3_ptr", {18'h0, or_addr}, 6);
    rmode = 0;

    // wrap-around through a 16382-byte packet
    do_reset();
    @(negedge iclk);
    push_len(16382);
    wait_done("t4_big_done", 20000);
    chk("t4_ptr_pre", {18'h0, or_addr}, 16382);
    @(negedge iclk);
    push_len(4);
    wait_done("t4_wrap_done", 100);
    chk("t4_ptr_post", {18'h0, or_addr}, 2);

    // zero-length word then single byte
    do_reset();
    np0 = npops;
    na0 = nacc;
    @(negedge iclk);
    push_len(0);
    push_len(1);
    wait_done("t5_done", 100);
    chk("t5_pops", npops - np0, 2);
    chk("t5_bytes", nacc - na0, 1);
    chk("t5_ptr", {18'h0, or_addr}, 1);

    // async reset during byte 3 of 8
    do_reset();
    na0 = nacc;
    @(negedge iclk);
    push_len(8);
    n = 0;
    while (nacc - na0 < 3 && n < 100) begin
      @(negedge iclk);
      n++;
    end
    chk("t6_mid_packet", {31'h0, (nacc - na0 >= 3)}, 1);
    do_reset();
    @(negedge iclk);
    push_len(2);
    wait_done("t6_restart_done", 100);
    chk("t6_ptr", {18'h0, or_addr}, 2);

    // randomized lengths and backpressure
    do_reset();
    rmode = 2;
    @(negedge iclk);
    for (int p = 0; p < 25; p++) push_len($urandom_range(0, 12));
    wait_done("rand_done", 3000);
    chk("rand_ptr", {18'h0, or_addr}, 32'(mptr));
    rmode = 0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
